// File: rtl/ahb_bram_pkg.sv
// ahb_bram_pkg: shared encodings for the AHB-Lite block RAM controller.
// Optional read forwarding is enabled with AHB_BRAM_FWD_EN.
package ahb_bram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [3:0] LANE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [31:0] byte_merge(
    input logic [3:0]  m,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = m[i] ? a[8*i +: 8] : b[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ahb_bram_if.sv
// ahb_bram_if: AHB-Lite slave-slot signals between interconnect and RAM bridge.
// Build option AHB_BRAM_FWD_EN does not change this interface.
interface ahb_bram_if #(
  parameter int HADDR_WIDTH = 32
);
  logic                   HSEL;
  logic [HADDR_WIDTH-1:0] HADDR;
  logic [1:0]             HTRANS;
  logic [2:0]             HSIZE;
  logic                   HWRITE;
  logic [31:0]            HWDATA;
  logic                   HREADY;
  logic                   HREADYOUT;
  logic                   HRESP;
  logic [31:0]            HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE,
    output HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE,
    input  HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_byte_lane_dec.sv
// ahb_byte_lane_dec: HSIZE/HADDR[1:0] to byte-lane mask and misalignment.
// Unaffected by AHB_BRAM_FWD_EN.
module ahb_byte_lane_dec
  import ahb_bram_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] mask,
  output logic       misalign
);

  always_comb begin
    mask     = '0;
    misalign = 1'b0;
    unique case (1'b1)
      (hsize == HSIZE_BYTE): mask = 4'b0001 << addr;
      (hsize == HSIZE_HALF): begin
        mask     = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
      end
      (hsize == HSIZE_WORD): begin
        mask     = LANE_ALL;
        misalign = |addr;
      end
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: zero-wait AHB-Lite responder for a read-first dual-port BRAM.
// Define AHB_BRAM_FWD_EN to forward write data on a same-word read hazard.
module ahb_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int HADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic                  hreadyout_q;
  logic                  hresp_q;

  logic [3:0]            lane;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] word;
  logic                  take;
  logic                  oob;
  logic                  err;
  logic                  hazard;
  logic                  stall_hz;
  logic [31:0]           rd_data;
  logic                  unused_htrans0;

  ahb_byte_lane_dec u_dec (
    .hsize    (bus.HSIZE),
    .addr     (bus.HADDR[1:0]),
    .mask     (lane),
    .misalign (misalign)
  );

  assign unused_htrans0 = bus.HTRANS[0];
  assign word   = bus.HADDR[ADDR_WIDTH+1:2];
  assign take   = bus.HSEL & bus.HTRANS[1]
                & bus.HREADY & hreadyout_q;
  assign oob    = |bus.HADDR[HADDR_WIDTH-1:ADDR_WIDTH+2];
  assign err    = (bus.HSIZE > HSIZE_WORD) | misalign | oob;
  assign hazard = (state == ST_WR) & ~bus.HWRITE
                & ~err & (word == addr_q);

`ifdef AHB_BRAM_FWD_EN
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  // Mask is cleared on every non-hazard accept, so RD merges only after a hazard.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_data <= '0;
      fwd_mask <= '0;
    end else if (take) begin
      fwd_data <= bus.HWDATA;
      fwd_mask <= hazard ? mask_q : 4'h0;
    end
  end

  assign stall_hz = 1'b0;
  assign rd_data  = byte_merge(fwd_mask, fwd_data, ram_doutb);
`else
  assign stall_hz = hazard;
  assign rd_data  = ram_doutb;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      unique case (state)
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        ST_STALL: begin
          state       <= ST_RD;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
        default: begin
          if (take) begin
            addr_q      <= word;
            mask_q      <= lane;
            hreadyout_q <= ~(err | stall_hz);
            hresp_q     <= err;
            state       <= err        ? ST_ERR1 :
                           bus.HWRITE ? ST_WR :
                           stall_hz   ? ST_STALL : ST_RD;
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = (state == ST_RD) ? rd_data : '0;

  assign ram_wea   = (state == ST_WR) ? mask_q : 4'h0;
  assign ram_addra = addr_q;
  assign ram_dina  = (state == ST_WR) ? bus.HWDATA : '0;
  // STALL re-presents the registered read address.
  assign ram_addrb = take ? word : addr_q;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb_ahb_bram_ctrl: directed AHB transfers against a transaction-level memory model.
// Wait-state expectations follow AHB_BRAM_FWD_EN when it is defined.
module tb_ahb_bram_ctrl;
  import ahb_bram_pkg::*;

  typedef struct {
    bit          valid;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  logic        HCLK;
  logic        HRESETn;
  logic [13:0] ram_addra;
  logic [31:0] ram_dina;
  logic [3:0]  ram_wea;
  logic [13:0] ram_addrb;
  logic [31:0] ram_doutb;

  ahb_bram_if #(.HADDR_WIDTH(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(14), .HADDR_WIDTH(32)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [31:0] bram    [0:16383];
  logic [31:0] ref_mem [0:16383];

  always @(posedge HCLK) begin
    ram_doutb <= bram[ram_addrb];
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) bram[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
  end

  int vecs = 0;
  int errs = 0;
  bit chk_en = 0;
  op_t dp;
  int dp_cyc = 0;
  int dp_expw = 0;
  op_t q[$];
  logic [31:0] last_rd = 0;
  int last_rd_wait = -1;
  logic [3:0] seen_wea = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal(op_t o);
    if (o.size > 3'd2) return 0;
    if ((o.addr & ((32'd1 << o.size) - 32'd1)) != 0) return 0;
    return o.addr < 32'h0001_0000;
  endfunction

  function automatic logic [3:0] lanes(op_t o);
    int nb;
    nb = 1 << o.size;
    return 4'(((1 << nb) - 1) << o.addr[1:0]);
  endfunction

  function automatic int expw(op_t prev, op_t cur);
    if (!cur.valid) return 0;
    if (!legal(cur)) return 1;
`ifndef AHB_BRAM_FWD_EN
    if (!cur.write && prev.valid && prev.write && legal(prev)
        && prev.addr[15:2] == cur.addr[15:2]) return 1;
`endif
    return 0;
  endfunction

  always @(negedge HCLK) begin : cmp
    logic [3:0] ew;
    logic [3:0] m;
    bit done;
    int w;
    if (chk_en) begin
      ew = (dp.valid && dp.write && legal(dp)) ? lanes(dp) : 4'h0;
      check("ram_wea", 32'(ram_wea), 32'(ew));
      if (ew != 0) begin
        check("ram_addra", 32'(ram_addra), 32'(dp.addr[15:2]));
        check("ram_dina", ram_dina, dp.wdata);
        seen_wea = ram_wea;
      end
      if (dp.valid) begin
        done = dp_cyc >= dp_expw;
        check("hreadyout", 32'(bus.HREADYOUT), 32'(done));
        check("hresp", 32'(bus.HRESP), 32'(!legal(dp)));
        if (done && legal(dp)) begin
          w = int'(dp.addr[15:2]);
          if (dp.write) begin
            m = lanes(dp);
            for (int i = 0; i < 4; i++)
              if (m[i]) ref_mem[w][8*i +: 8] = dp.wdata[8*i +: 8];
          end else begin
            check("hrdata", bus.HRDATA, ref_mem[w]);
            last_rd = bus.HRDATA;
            last_rd_wait = dp_cyc;
          end
        end
      end else begin
        check("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("idle_hresp", 32'(bus.HRESP), 32'd0);
      end
      dp_cyc++;
    end
  end

  function automatic op_t mk(bit wr, logic [31:0] a, logic [2:0] s,
                             logic [31:0] d);
    op_t o;
    o.valid = 1; o.write = wr; o.addr = a; o.size = s; o.wdata = d;
    return o;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [2:0] s,
                    input logic [31:0] d);
    q.push_back(mk(1, a, s, d));
  endtask

  task automatic rd(input logic [31:0] a);
    q.push_back(mk(0, a, HSIZE_WORD, 32'h0));
  endtask

  task automatic drive(input op_t a);
    bus.HSEL   = a.valid;
    bus.HTRANS = a.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.HADDR  = a.valid ? a.addr : 32'h0;
    bus.HWRITE = a.valid & a.write;
    bus.HSIZE  = a.valid ? a.size : 3'd0;
  endtask

  task automatic go();
    op_t ap;
    bit rdy;
    int stall;
    int idx;
    stall = 0;
    idx = 0;
    ap.valid = 0;
    if (q.size() > 0) begin ap = q[0]; idx = 1; end
    drive(ap);
    do begin
      @(negedge HCLK);
      rdy = bus.HREADYOUT;
      @(posedge HCLK);
      #1;
      if (rdy) begin
        dp_expw = expw(dp, ap);
        dp = ap;
        dp_cyc = 0;
        stall = 0;
        if (idx < q.size()) begin ap = q[idx]; idx++; end
        else ap.valid = 0;
        drive(ap);
        bus.HWDATA = (dp.valid && dp.write) ? dp.wdata : 32'h0;
      end else if (++stall > 8) begin
        errs++;
        vecs++;
        $display("FAIL bus_timeout: got %0d stalls required <=8", stall);
        ap.valid = 0;
        dp.valid = 0;
        drive(ap);
        break;
      end
    end while (ap.valid || dp.valid);
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      bram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    dp.valid = 0;
    HRESETn = 0;
    bus.HSEL = 0; bus.HTRANS = HTRANS_IDLE; bus.HADDR = 0;
    bus.HWRITE = 0; bus.HSIZE = 0; bus.HWDATA = 0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus.HRESP), 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_wea", 32'(ram_wea), 32'h0);
    check("rst_addra", 32'(ram_addra), 32'h0);
    check("rst_dina", ram_dina, 32'h0);
    check("rst_addrb", 32'(ram_addrb), 32'h0);
    @(negedge HCLK) HRESETn = 1;
    @(posedge HCLK);
    #1;
    chk_en = 1;

    wr(32'h2, HSIZE_BYTE, 32'h00AB_0000); go();
    rd(32'h0); go();
    check("lit_byte_wea", 32'(seen_wea), 32'h4);
    check("lit_byte_rd", last_rd, 32'h00AB_0000);
    check("lit_byte_wait", 32'(last_rd_wait), 32'd0);

    wr(32'h10, HSIZE_WORD, 32'h1234_5678); rd(32'h10); go();
    check("lit_hz_rd", last_rd, 32'h1234_5678);
`ifdef AHB_BRAM_FWD_EN
    check("lit_hz_wait", 32'(last_rd_wait), 32'd0);
`else
    check("lit_hz_wait", 32'(last_rd_wait), 32'd1);
`endif

    wr(32'h20, HSIZE_WORD, 32'h1122_3344);
    wr(32'h22, HSIZE_HALF, 32'hBEEF_0000);
    rd(32'h20); go();
    check("lit_half_rd", last_rd, 32'hBEEF_3344);

    wr(32'h21, HSIZE_HALF, 32'hFFFF_FFFF);
    wr(32'h22, HSIZE_WORD, 32'hFFFF_FFFF);
    wr(32'h8, 3'd3, 32'hFFFF_FFFF);
    rd(32'h20); go();
    check("lit_err_nowrite", last_rd, 32'hBEEF_3344);

    rd(32'h0001_0000); rd(32'h10); go();
    check("lit_oob_next", last_rd, 32'h1234_5678);

    wr(32'h30, HSIZE_BYTE, 32'h0000_0011);
    wr(32'h31, HSIZE_BYTE, 32'h0000_2200);
    wr(32'h40, HSIZE_WORD, 32'h5555_AAAA);
    rd(32'h30); go();
    check("lit_b2b_rd", last_rd, 32'h0000_2211);
    check("lit_b2b_wait", 32'(last_rd_wait), 32'd0);

    wr(32'h33, HSIZE_BYTE, 32'h7700_0000);
    wr(32'h32, HSIZE_HALF, 32'h9900_0000);
    rd(32'h30); rd(32'h40); rd(32'h20); go();

    chk_en = 0;
    bus.HSEL = 1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1;
    bus.HSIZE = HSIZE_WORD; bus.HADDR = 32'h50;
    @(posedge HCLK);
    #1;
    dp.valid = 0;
    drive(dp);
    bus.HWDATA = 32'hCAFE_F00D;
    check("rst_mid_pre_wea", 32'(ram_wea), 32'hF);
    #2 HRESETn = 0;
    #1;
    check("rst_mid_wea", 32'(ram_wea), 32'h0);
    check("rst_mid_addra", 32'(ram_addra), 32'h0);
    check("rst_mid_dina", ram_dina, 32'h0);
    check("rst_mid_addrb", 32'(ram_addrb), 32'h0);
    check("rst_mid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_mid_hresp", 32'(bus.HRESP), 32'd0);
    check("rst_mid_hrdata", bus.HRDATA, 32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1;
    check("rst_mid_nowrite", bram[20], 32'h0);
    @(posedge HCLK);
    #1;
    chk_en = 1;
    rd(32'h50); wr(32'h50, HSIZE_WORD, 32'h0BAD_F00D); go();
    rd(32'h50); go();
    check("lit_post_rst_rd", last_rd, 32'h0BAD_F00D);

    repeat (2) @(posedge HCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite responder that lets the Cortex-M0 bus master read and write the dual-port code/data block RAM. Incoming AHB transfers become RAM port signals: write port `addra`/`dina`/`wea[3:0]` with per-byte enables, and read port `addrb`/`doutb`. It returns zero-wait-state reads and writes, and detects the case where a read is issued to the word being written in the same cycle. It sits between the AHB-Lite interconnect slave slot and the block RAM instance.

## Interface
- ADDR_WIDTH, 14, RAM word-address width; region size is 4·2^ADDR_WIDTH bytes.
- HADDR_WIDTH, 32, AHB address width.
- HCLK  in  1  bus clock; also drives the RAM `clka`.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_WIDTH  byte address.
- HTRANS  in  2  transfer type; only bit 1 is examined (NONSEQ/SEQ).
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWRITE  in  1  write when 1.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- ram_addra  out  ADDR_WIDTH  write word address.
- ram_dina  out  32  write data.
- ram_wea  out  4  byte write enables.
- ram_addrb  out  ADDR_WIDTH  read word address.
- ram_doutb  in  32  registered RAM read data (1-cycle latency).

## Operation
- An address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance the block registers the word address, HWRITE, the lane mask and the error flag.
- Lane mask rules:
  - HSIZE=0 → one lane, selected by HADDR[1:0].
  - HSIZE=1 → lanes {1,0} when HADDR[1]=0, lanes {3,2} otherwise.
  - HSIZE=2 → 4'hF.
- A transfer is an error when any of these holds:
  - HSIZE>2.
  - HSIZE=1 with HADDR[0]=1.
  - HSIZE=2 with HADDR[1:0]≠0.
  - Any HADDR bit in [HADDR_WIDTH-1 : ADDR_WIDTH+2] is nonzero.
- FSM states:
  - IDLE → RD or WR on an accepted, legal transfer; → ERR1 on an illegal one.
  - RD and WR are each a single data-phase cycle. They chain directly into the next accepted transfer, or return to IDLE.
  - STALL is a read wait state and is reachable only without the forwarding feature (see Configuration). It always goes to RD.
  - ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → IDLE, or accept a new transfer at the end of ERR2.
- Write data phase (state WR): drive `ram_addra` from the registered address, `ram_dina` from HWDATA, and `ram_wea` from the registered mask. `ram_wea` is 0 in every other state.
- Read:
  - `ram_addrb` is the HADDR word address during the address phase.
  - In STALL, `ram_addrb` is the registered read address.
  - In RD, HRDATA = `ram_doutb`, with forwarded bytes substituted when the forwarding feature is compiled in.
- Hazard: a read address phase accepted while in WR with the same word address. The RAM is read-first, so `ram_doutb` returns the pre-write data.
- Errored transfers never assert `ram_wea`.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - `ram_wea`=0, `ram_addra`=0, `ram_dina`=0, `ram_addrb`=0.
  - State=IDLE, all registered phase state cleared.
- Reset asserted mid-transfer: the block returns to IDLE immediately and `ram_wea` drops asynchronously. No partial write is issued after reset deassertion.
- Reads and writes take zero wait states, with a 1-cycle data phase.
- A hazard costs zero waits with forwarding and exactly one wait (STALL) without it.
- While HREADYOUT=0, new address phases are not accepted (HREADY low).
- Back-to-back writes, including to the same word, take zero waits.
- A write followed by a read of a different word takes zero waits.

## Configuration
- AHB_BRAM_FWD_EN defined:
  - On a hazard, capture HWDATA and the write mask at the hazard edge.
  - In the following RD cycle, each HRDATA byte comes from the captured data where the mask bit is 1, and from `ram_doutb` otherwise.
  - No STALL state exists.
- AHB_BRAM_FWD_EN undefined:
  - On a hazard, enter STALL with HREADYOUT=0 and re-present `ram_addrb`.
  - The next cycle is RD with HREADYOUT=1 and fresh `ram_doutb`.

## Structure
- Package ahb_bram_pkg holds:
  - HTRANS, HSIZE and HRESP encodings.
  - The FSM state encoding (IDLE, RD, WR, STALL, ERR1, ERR2).
  - A LANE_ALL constant (4'hF).
- Sub-module ahb_byte_lane_dec is combinational: inputs HSIZE and HADDR[1:0]; outputs the lane mask[3:0] and the misaligned flag.

## Test plan
- Byte write 0xAB to 0x0000_0002, then word read 0x0 → RAM holds 0x00AB_0000 (from preload 0), `ram_wea`=4'b0100, read returns 0x00AB0000 with zero waits.
- Word write 0x1234_5678 to 0x10 immediately followed by a read of 0x10 → HRDATA=0x12345678. With AHB_BRAM_FWD_EN there are 0 waits; without it, exactly 1 cycle HREADYOUT=0.
- Halfword write 0xBEEF to 0x22 then read 0x20 → upper half = 0xBEEF, lower half unchanged.
- Halfword at 0x01 or word at 0x02 → two-cycle ERROR (ERR1 with HREADYOUT=0, then ERR2 with HREADYOUT=1, HRESP=1 in both), `ram_wea` never asserted.
- HADDR = 4·2^ADDR_WIDTH → ERROR response. A following legal read returns OKAY with correct data.
- HRESETn pulsed low during a write data phase → `ram_wea`=0 immediately, all outputs at reset values, first post-reset transfer completes normally.
